fetch_stage: RTL

//  Instruction-fetch stage plus IF/ID pipeline register of the LEGv8 pipelined CPU. Owns the PC and

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/branch_target_gen.sv | 47 ++++
 rtl/fetch_stage.sv | 95 +++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared LEGv8 pipeline definitions: branch opcode patterns on instr[31:21] and fetch constants.
// The patterns use ? as a wildcard and are meant for casez.
package cpu_pkg;

  localparam logic [10:0] OPC_B     = 11'b000101?????;
  localparam logic [10:0] OPC_BL    = 11'b100101?????;
  localparam logic [10:0] OPC_CBZ   = 11'b10110100???;
  localparam logic [10:0] OPC_CBNZ  = 11'b10110101???;
  localparam logic [10:0] OPC_BCOND = 11'b01010100???;
  localparam logic [10:0] OPC_BR    = 11'b11010110000;

  localparam logic [31:0] NOP_INSTR   = 32'h0;
  localparam int          INSTR_BYTES = 4;

  typedef enum logic [1:0] {
    TGT_REG   = 2'd0,
    TGT_IMM26 = 2'd1,
    TGT_IMM19 = 2'd2
  } tgt_sel_t;

endpackage

// File: rtl/branch_target_gen.sv
// Branch target for the instruction held in IF/ID: register target, imm26 (B/BL)
// or imm19 (CBZ/CBNZ/B.cond) PC-relative offset. Purely combinational.
import cpu_pkg::*;

module branch_target_gen #(
  parameter int ADDR_W = 64
) (
  input  logic [31:0]       id_instr,
  input  logic [ADDR_W-1:0] id_pc,
  input  logic              br_reg,
  input  logic              uncond_branch,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] target
);

  logic [ADDR_W-1:0] off26;
  logic [ADDR_W-1:0] off19;
  tgt_sel_t          sel;

  assign off26 = {{(ADDR_W-28){id_instr[25]}}, id_instr[25:0], 2'b00};
  assign off19 = {{(ADDR_W-21){id_instr[23]}}, id_instr[23:5], 2'b00};

  // Decode's Uncondbranch also marks B/BL, so it selects the imm26 form directly.
  always_comb begin
    sel = TGT_IMM19;
    if (br_reg) begin
      sel = TGT_REG;
    end else if (uncond_branch) begin
      sel = TGT_IMM26;
    end else begin
      casez (id_instr[31:21])
        OPC_B, OPC_BL: sel = TGT_IMM26;
        default:       sel = TGT_IMM19;
      endcase
    end
  end

  always_comb begin
    target = id_pc + off19;
    case (sel)
      TGT_REG:   target = br_target;
      TGT_IMM26: target = id_pc + off26;
      default:   target = id_pc + off19;
    endcase
  end

endmodule

// File: rtl/fetch_stage.sv
// LEGv8 instruction fetch plus IF/ID register: owns the PC, applies decode-resolved
// redirects with a one-cycle squash, and flags bubbles to the control unit.
import cpu_pkg::*;

module fetch_stage #(
  parameter int              ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_rdata,
  input  logic              imem_valid,
  input  logic              stall,
  input  logic              branch_taken,
  input  logic              uncond_branch,
  input  logic              br_reg,
  input  logic [ADDR_W-1:0] br_target,
  output logic [31:0]       id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_link,
  output logic              id_valid,
  output logic              controloff,
  output logic [31:0]       fetch_count
);

  logic [ADDR_W-1:0] pc_reg, pc_next;
  logic [31:0]       instr_reg, instr_next;
  logic [ADDR_W-1:0] idpc_reg, idpc_next;
  logic              valid_reg, valid_next;
  logic [31:0]       count_reg, count_next;
  logic [ADDR_W-1:0] target;
  logic              redirect;

  branch_target_gen #(.ADDR_W(ADDR_W)) u_target (
    .id_instr      (instr_reg),
    .id_pc         (idpc_reg),
    .br_reg        (br_reg),
    .uncond_branch (uncond_branch),
    .br_target     (br_target),
    .target        (target)
  );

  // Flags/operands of a stalled ID instruction are stale, so stall blocks the redirect.
  assign redirect = branch_taken & valid_reg & ~stall;

  always_comb begin
    pc_next    = pc_reg;
    instr_next = instr_reg;
    idpc_next  = idpc_reg;
    valid_next = valid_reg;
    count_next = count_reg;
    if (stall) begin
      pc_next = pc_reg;
    end else if (redirect) begin
      pc_next    = target;
      instr_next = NOP_INSTR;
      valid_next = 1'b0;
    end else if (imem_valid) begin
      pc_next    = pc_reg + ADDR_W'(INSTR_BYTES);
      instr_next = imem_rdata;
      idpc_next  = pc_reg;
      valid_next = 1'b1;
      count_next = count_reg + 32'd1;
    end else begin
      instr_next = NOP_INSTR;
      valid_next = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg    <= RESET_PC;
      instr_reg <= NOP_INSTR;
      idpc_reg  <= '0;
      valid_reg <= 1'b0;
      count_reg <= 32'd0;
    end else begin
      pc_reg    <= pc_next;
      instr_reg <= instr_next;
      idpc_reg  <= idpc_next;
      valid_reg <= valid_next;
      count_reg <= count_next;
    end
  end

  assign imem_addr   = pc_reg;
  assign id_instr    = instr_reg;
  assign id_pc       = idpc_reg;
  assign id_valid    = valid_reg;
  assign id_link     = idpc_reg + ADDR_W'(INSTR_BYTES);
  assign controloff  = ~valid_reg | stall;
  assign fetch_count = count_reg;

endmodule
